// File: rtl/l2_request_queue.sv
// l2_request_queue
// FIFO between the core's L2 request bus (pci_*) and the L2 cache pipeline.
// Requests are accepted with a combinational ack, stored in order, and
// presented show-ahead on a valid/ready interface. A free-running counter
// tallies accepted requests for performance monitoring.
module l2_request_queue #(
  parameter int QUEUE_DEPTH = 4,
  parameter int PTR_WIDTH   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pci_valid_i,
  output logic                 pci_ack_o,
  input  logic [1:0]           pci_unit_i,
  input  logic [1:0]           pci_strand_i,
  input  logic [2:0]           pci_op_i,
  input  logic [1:0]           pci_way_i,
  input  logic [25:0]          pci_address_i,
  input  logic [511:0]         pci_data_i,
  input  logic [63:0]          pci_mask_i,
  output logic                 rq_valid_o,
  input  logic                 rq_ready_i,
  output logic [1:0]           rq_unit_o,
  output logic [1:0]           rq_strand_o,
  output logic [2:0]           rq_op_o,
  output logic [1:0]           rq_way_o,
  output logic [25:0]          rq_address_o,
  output logic [511:0]         rq_data_o,
  output logic [63:0]          rq_mask_o,
  output logic [PTR_WIDTH:0]   rq_count_o,
  output logic                 rq_full_o,
  output logic [31:0]          perf_accepted_o
);

  typedef struct packed {
    logic [1:0]   unit;
    logic [1:0]   strand;
    logic [2:0]   op;
    logic [1:0]   way;
    logic [25:0]  address;
    logic [511:0] data;
    logic [63:0]  mask;
  } entry_t;

  localparam logic [PTR_WIDTH:0] FULL_COUNT = QUEUE_DEPTH[PTR_WIDTH:0];

  entry_t               entry_mem [QUEUE_DEPTH];
  entry_t               head_entry;
  logic [PTR_WIDTH-1:0] wr_ptr_reg;
  logic [PTR_WIDTH-1:0] rd_ptr_reg;
  logic [PTR_WIDTH:0]   count_reg;
  logic [31:0]          perf_accepted_reg;
  logic                 push;
  logic                 pop;

  // Ack depends only on registered occupancy, never on rq_ready_i, so a
  // pop in the same cycle cannot free a slot for an incoming request.
  assign rq_full_o  = (count_reg == FULL_COUNT);
  assign rq_valid_o = (count_reg != '0);
  assign push       = pci_valid_i & ~rq_full_o & ~reset;
  assign pop        = rq_valid_o & rq_ready_i;
  assign pci_ack_o  = push;

  assign rq_count_o      = count_reg;
  assign perf_accepted_o = perf_accepted_reg;

  // Show-ahead head: outputs read storage directly at the read pointer.
  assign head_entry   = entry_mem[rd_ptr_reg];
  assign rq_unit_o    = head_entry.unit;
  assign rq_strand_o  = head_entry.strand;
  assign rq_op_o      = head_entry.op;
  assign rq_way_o     = head_entry.way;
  assign rq_address_o = head_entry.address;
  assign rq_data_o    = head_entry.data;
  assign rq_mask_o    = head_entry.mask;

  // Entry storage: written at the write pointer on every accepted request; never cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_mem[wr_ptr_reg] <= '{
        unit:    pci_unit_i,
        strand:  pci_strand_i,
        op:      pci_op_i,
        way:     pci_way_i,
        address: pci_address_i,
        data:    pci_data_i,
        mask:    pci_mask_i
      };
    end
  end

  // Pointers and occupancy; push and pop together leave occupancy unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !push) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  // Accepted-request counter, wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_accepted_reg <= '0;
    end else if (push) begin
      perf_accepted_reg <= perf_accepted_reg + 32'd1;
    end
  end

endmodule

// File: doc/l2_request_queue.md
Name: l2_request_queue

Overview:
- Downstream of the core's L2 arbiter mux: consumes the core's pci_* request bus and buffers requests in a FIFO in front of the L2 cache pipeline.
- Decouples core issue from L2 pipeline stalls. Requests leave in strict arrival order on a valid/ready interface.
- Also keeps a running count of accepted requests for performance monitoring.

Parameters:
- QUEUE_DEPTH, 4, number of request entries; must be a power of two and at least 2.
- PTR_WIDTH, 2, log2(QUEUE_DEPTH); width of the read/write pointers.

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- pci_valid_i  input  1  core request valid; held by core until acked.
- pci_ack_o  output  1  request accepted this cycle.
- pci_unit_i  input  2  requesting unit (0 icache, 1 dcache, 2 store buffer).
- pci_strand_i  input  2  requesting strand.
- pci_op_i  input  3  request opcode.
- pci_way_i  input  2  L1 way.
- pci_address_i  input  26  cache-line address.
- pci_data_i  input  512  line data.
- pci_mask_i  input  64  byte mask.
- rq_valid_o  output  1  head entry valid toward L2 pipeline.
- rq_ready_i  input  1  L2 pipeline consumes head this cycle.
- rq_unit_o, rq_strand_o, rq_op_o, rq_way_o, rq_address_o, rq_data_o, rq_mask_o  output  2/2/3/2/26/512/64  head entry fields.
- rq_count_o  output  PTR_WIDTH+1  current occupancy, 0..QUEUE_DEPTH.
- rq_full_o  output  1  occupancy == QUEUE_DEPTH.
- perf_accepted_o  output  32  total accepted requests.

Behaviour:
- Reset is synchronous, active-high, and fixed as such. On a clk edge with reset=1:
  - Read and write pointers, occupancy and perf_accepted_o are cleared to 0.
  - Consequently rq_valid_o=0, rq_count_o=0, rq_full_o=0 from the following cycle.
  - pci_ack_o=0 whenever reset=1.
  - Entry storage is not cleared. rq_* data fields are don't-care while rq_valid_o=0.
- Reset mid-operation discards all queued entries. A request acked in the same cycle as reset is dropped and not counted.
- Enqueue handshake:
  - pci_ack_o = pci_valid_i & ~rq_full_o & ~reset, combinational.
  - On a cycle with pci_ack_o=1, all pci_* fields are written at the write pointer and the write pointer increments modulo QUEUE_DEPTH.
  - The core drops or changes its request on the cycle after ack. The queue never acks the same request twice, because ack is only level-per-cycle.
- Dequeue:
  - rq_valid_o = (occupancy != 0). Outputs show the head entry (show-ahead, read directly from storage at the read pointer).
  - Pop occurs when rq_valid_o & rq_ready_i. The read pointer increments modulo QUEUE_DEPTH.
  - rq_ready_i while empty is ignored.
- Latency: a request acked on cycle N appears on rq_valid_o on cycle N+1 at the earliest. There is no empty bypass.
- Occupancy:
  - Push only: +1. Pop only: -1. Push and pop together: unchanged, both pointers advance.
- Full:
  - rq_full_o=1 blocks ack even if a pop occurs the same cycle. There is no full-bypass, so ack never depends on rq_ready_i.
  - The entry frees on the next cycle.
- Pointers wrap from QUEUE_DEPTH-1 to 0. Ordering is strict FIFO across all units and strands.
- perf_accepted_o increments by 1 on each ack and wraps 0xFFFFFFFF -> 0.
- All outputs other than pci_ack_o are registered state or direct reads of it; there is no combinational path from rq_ready_i to pci_ack_o.

Test Plan:
- Reset, then single push: pci_valid_i=1, unit=1, strand=2, op=3'd1, addr=26'h0123456, data=512'hA5..A5, mask=64'hFFFF_FFFF_FFFF_FFFF, rq_ready_i=0.
  - Expect pci_ack_o=1 on cycle 0.
  - Expect rq_valid_o=1 on cycle 1 with identical fields; rq_count_o=1; perf_accepted_o=1.
- Fill with rq_ready_i=0: push addresses 1,2,3,4, then hold valid with addr 5.
  - Expect ack on the first 4 only; rq_full_o=1 and rq_count_o=4.
  - Addr 5 is not acked until the cycle after the first pop.
- Full with a simultaneous pop: queue full, rq_ready_i=1 and pci_valid_i=1 on the same cycle.
  - Expect pci_ack_o=0 that cycle; rq_count_o=3 next cycle.
  - Expect ack of the pending request the following cycle; rq_count_o returns to 4.
- Streaming with rq_ready_i held at 1: push addresses 0..9 back-to-back.
  - Expect rq_count_o to stay at 1 in steady state and output addresses 0..9 in order across at least 2 pointer wraps.
  - Expect perf_accepted_o=10.
- Reset mid-operation: 3 entries queued, then reset=1 for one cycle while pci_valid_i=1.
  - Expect pci_ack_o=0; the next cycle rq_valid_o=0, rq_count_o=0, perf_accepted_o=0.
  - Expect a subsequent push to emerge as the first entry.
- Counter wrap: force perf_accepted_o near its limit (preload via 0xFFFFFFFF pushes or hierarchical deposit), then push one request.
  - Expect perf_accepted_o to go 0xFFFFFFFF -> 0 with the queue contents unaffected.
